// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/mem/writeback.
// Ports: clock, reset, instruction, zero -> stage, ALU controls, strobes,
// illegal, and retired_count when MULTICYCLE_CONTROL_PERF_EN is defined.
module multicycle_control (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  output logic [2:0]  stage,
  output logic [1:0]  alu_op,
  output logic [5:0]  alu_funct,
  output logic        alu_src,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        pc_write,
  output logic        pc_branch,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        illegal
`ifdef MULTICYCLE_CONTROL_PERF_EN
  ,
  output logic [31:0] retired_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_LW, C_SW, C_ADDI, C_BEQ, C_HALT, C_ILL
  } cls_t;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  state_t state_q;
  cls_t   cls_q;

  assign stage = state_q;

  logic [5:0] opc;
  cls_t       dec_cls;
  logic [1:0] dec_op;
  logic [5:0] dec_funct;
  logic       dec_src;
  logic       dec_dst;
  logic       dec_m2r;

  assign opc = instruction[31:26];

  // Operand fields are consumed by the datapath, not by control.
  logic unused_fields;
  assign unused_fields = ^instruction[25:6];

  always_comb begin
    dec_cls   = C_ILL;
    dec_op    = 2'b00;
    dec_funct = FUNCT_ADD;
    dec_src   = 1'b0;
    dec_dst   = 1'b0;
    dec_m2r   = 1'b0;
    unique case (1'b1)
      (opc == 6'b000000): begin
        dec_cls   = C_R;
        dec_op    = 2'b10;
        dec_dst   = 1'b1;
        dec_funct = instruction[5:0];
      end
      (opc == 6'b100011): begin
        dec_cls = C_LW;
        dec_src = 1'b1;
        dec_m2r = 1'b1;
      end
      (opc == 6'b101011): begin
        dec_cls = C_SW;
        dec_src = 1'b1;
      end
      (opc == 6'b001000): begin
        dec_cls = C_ADDI;
        dec_src = 1'b1;
      end
      (opc == 6'b000100): begin
        dec_cls = C_BEQ;
        dec_op  = 2'b01;
      end
      (opc == 6'b111111): begin
        dec_cls = C_HALT;
      end
      default: ;
    endcase
  end

  // Stage 0 with pc_write low only exists right after reset; it
  // becomes a real fetch cycle (pc_write high) on the next edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_FETCH;
      cls_q      <= C_ILL;
      alu_op     <= 2'b00;
      alu_funct  <= FUNCT_ADD;
      alu_src    <= 1'b0;
      reg_dst    <= 1'b0;
      mem_to_reg <= 1'b0;
      pc_write   <= 1'b0;
      pc_branch  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      reg_write  <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      pc_write  <= 1'b0;
      pc_branch <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
      unique case (state_q)
        S_FETCH: begin
          if (pc_write) begin
            state_q    <= S_DECODE;
            cls_q      <= dec_cls;
            alu_op     <= dec_op;
            alu_funct  <= dec_funct;
            alu_src    <= dec_src;
            reg_dst    <= dec_dst;
            mem_to_reg <= dec_m2r;
            illegal    <= (dec_cls == C_ILL);
          end else begin
            pc_write <= 1'b1;
          end
        end
        S_DECODE: begin
          if (cls_q == C_ILL) begin
            state_q  <= S_FETCH;
            pc_write <= 1'b1;
          end else if (cls_q == C_HALT) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls_q == C_R || cls_q == C_ADDI) begin
            state_q   <= S_WB;
            reg_write <= 1'b1;
          end else begin
            state_q   <= S_MEM;
            mem_read  <= (cls_q == C_LW);
            mem_write <= (cls_q == C_SW);
            pc_branch <= (cls_q == C_BEQ) && zero;
          end
        end
        S_MEM: begin
          if (cls_q == C_LW) begin
            state_q   <= S_WB;
            reg_write <= 1'b1;
          end else begin
            state_q  <= S_FETCH;
            pc_write <= 1'b1;
          end
        end
        S_WB: begin
          state_q  <= S_FETCH;
          pc_write <= 1'b1;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

`ifdef MULTICYCLE_CONTROL_PERF_EN
  // Only stages 3/4 return to fetch for legal instructions; an
  // illegal opcode returns from stage 1 and is not counted.
  logic        retire;
  logic [31:0] count_q;

  assign retire = (state_q == S_WB) ||
                  (state_q == S_MEM && cls_q != C_LW);

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (retire) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign retired_count = count_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with a per-cycle
// expectation queue and immediate assertions.
module tb_multicycle_control;

  logic        clock;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic [2:0]  stage;
  logic [1:0]  alu_op;
  logic [5:0]  alu_funct;
  logic        alu_src;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        pc_write;
  logic        pc_branch;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        illegal;
`ifdef MULTICYCLE_CONTROL_PERF_EN
  logic [31:0] retired_count;
`endif

  multicycle_control dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .zero        (zero),
    .stage       (stage),
    .alu_op      (alu_op),
    .alu_funct   (alu_funct),
    .alu_src     (alu_src),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .pc_write    (pc_write),
    .pc_branch   (pc_branch),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .illegal     (illegal)
`ifdef MULTICYCLE_CONTROL_PERF_EN
    ,
    .retired_count (retired_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // strobe vector: {pc_write, pc_branch, mem_read, mem_write, reg_write, illegal}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] PCW  = 6'b100000;
  localparam logic [5:0] PCB  = 6'b010000;
  localparam logic [5:0] MRD  = 6'b001000;
  localparam logic [5:0] MWR  = 6'b000100;
  localparam logic [5:0] RGW  = 6'b000010;
  localparam logic [5:0] ILL  = 6'b000001;

  // decoded vector: {alu_op, alu_funct, alu_src, reg_dst, mem_to_reg}
  localparam logic [10:0] D_RST  = {2'b00, 6'b100000, 3'b000};
  localparam logic [10:0] D_ADD  = {2'b10, 6'b100000, 3'b010};
  localparam logic [10:0] D_SUB  = {2'b10, 6'b100010, 3'b010};
  localparam logic [10:0] D_LW   = {2'b00, 6'b100000, 3'b101};
  localparam logic [10:0] D_SW   = {2'b00, 6'b100000, 3'b100};
  localparam logic [10:0] D_ADDI = {2'b00, 6'b100000, 3'b100};
  localparam logic [10:0] D_BEQ  = {2'b01, 6'b100000, 3'b000};

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_SUB  = 32'h01095022;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_ADDI = 32'h21280005;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_ILL  = 32'h44000000;
  localparam logic [31:0] I_HALT = 32'hFC000000;
  localparam logic [31:0] I_JUNK = 32'hFC00003F;

  typedef struct {
    string       tag;
    logic [2:0]  stage;
    logic [5:0]  strb;
    logic        chk_dec;
    logic [10:0] dec;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic step(input string tag, input logic [2:0] st,
                      input logic [5:0] sb, input logic cd,
                      input logic [10:0] dv);
    exp_t e;
    exp_t g;
    logic [5:0]  got_sb;
    logic [10:0] got_dv;
    e.tag = tag; e.stage = st; e.strb = sb; e.chk_dec = cd; e.dec = dv;
    q.push_back(e);
    @(negedge clock);
    g = q.pop_front();
    got_sb = {pc_write, pc_branch, mem_read, mem_write, reg_write, illegal};
    got_dv = {alu_op, alu_funct, alu_src, reg_dst, mem_to_reg};
    n_assert++;
    assert (stage === g.stage) else begin
      n_fail++;
      $error("FAIL %s stage got %0d exp %0d", g.tag, stage, g.stage);
    end
    n_assert++;
    assert (got_sb === g.strb) else begin
      n_fail++;
      $error("FAIL %s strobes got %b exp %b", g.tag, got_sb, g.strb);
    end
    if (g.chk_dec) begin
      n_assert++;
      assert (got_dv === g.dec) else begin
        n_fail++;
        $error("FAIL %s decode got %b exp %b", g.tag, got_dv, g.dec);
      end
    end
  endtask

`ifdef MULTICYCLE_CONTROL_PERF_EN
  task automatic chk_cnt(input string tag, input logic [31:0] exp_v);
    n_assert++;
    assert (retired_count === exp_v) else begin
      n_fail++;
      $error("FAIL %s retired_count got %h exp %h", tag, retired_count, exp_v);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    instruction = 32'h0;
    zero = 1'b0;
    repeat (2) @(posedge clock);
    step("rst", 3'd0, NONE, 1'b1, D_RST);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk_cnt("cnt.rst", 32'd0);
`endif
    reset = 1'b0;
    step("boot", 3'd0, PCW, 1'b1, D_RST);

    instruction = I_ADD;
    step("add.1", 3'd1, NONE, 1'b1, D_ADD);
    instruction = I_JUNK;
    step("add.2", 3'd2, NONE, 1'b1, D_ADD);
    step("add.4", 3'd4, RGW,  1'b1, D_ADD);
    step("add.0", 3'd0, PCW,  1'b1, D_ADD);

    instruction = I_SUB;
    step("sub.1", 3'd1, NONE, 1'b1, D_SUB);
    instruction = I_JUNK;
    step("sub.2", 3'd2, NONE, 1'b1, D_SUB);
    step("sub.4", 3'd4, RGW,  1'b1, D_SUB);
    step("sub.0", 3'd0, PCW,  1'b0, D_SUB);

    instruction = I_LW;
    step("lw.1", 3'd1, NONE, 1'b1, D_LW);
    instruction = I_JUNK;
    step("lw.2", 3'd2, NONE, 1'b1, D_LW);
    step("lw.3", 3'd3, MRD,  1'b1, D_LW);
    step("lw.4", 3'd4, RGW,  1'b1, D_LW);
    step("lw.0", 3'd0, PCW,  1'b0, D_LW);

    instruction = I_SW;
    step("sw.1", 3'd1, NONE, 1'b1, D_SW);
    instruction = I_JUNK;
    step("sw.2", 3'd2, NONE, 1'b1, D_SW);
    step("sw.3", 3'd3, MWR,  1'b1, D_SW);
    step("sw.0", 3'd0, PCW,  1'b0, D_SW);

    instruction = I_ADDI;
    step("addi.1", 3'd1, NONE, 1'b1, D_ADDI);
    instruction = I_JUNK;
    step("addi.2", 3'd2, NONE, 1'b1, D_ADDI);
    step("addi.4", 3'd4, RGW,  1'b1, D_ADDI);
    step("addi.0", 3'd0, PCW,  1'b0, D_ADDI);

    instruction = I_BEQ;
    zero = 1'b1;
    step("beq1.1", 3'd1, NONE, 1'b1, D_BEQ);
    instruction = I_JUNK;
    step("beq1.2", 3'd2, NONE, 1'b1, D_BEQ);
    step("beq1.3", 3'd3, PCB,  1'b1, D_BEQ);
    step("beq1.0", 3'd0, PCW,  1'b0, D_BEQ);

    instruction = I_BEQ;
    zero = 1'b0;
    step("beq0.1", 3'd1, NONE, 1'b1, D_BEQ);
    instruction = I_JUNK;
    step("beq0.2", 3'd2, NONE, 1'b1, D_BEQ);
    step("beq0.3", 3'd3, NONE, 1'b1, D_BEQ);
    step("beq0.0", 3'd0, PCW,  1'b0, D_BEQ);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk_cnt("cnt.seven", 32'd7);
`endif

    instruction = I_ILL;
    step("ill.1", 3'd1, ILL, 1'b0, D_RST);
    instruction = I_JUNK;
    step("ill.0", 3'd0, PCW, 1'b0, D_RST);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk_cnt("cnt.ill", 32'd7);
`endif

    // Reset lands on the edge that would have entered stage 3.
    instruction = I_SW;
    step("swr.1", 3'd1, NONE, 1'b1, D_SW);
    instruction = I_JUNK;
    step("swr.2", 3'd2, NONE, 1'b1, D_SW);
    reset = 1'b1;
    step("swr.rst", 3'd0, NONE, 1'b1, D_RST);
`ifdef MULTICYCLE_CONTROL_PERF_EN
    chk_cnt("cnt.swr", 32'd0);
`endif
    reset = 1'b0;
    step("swr.boot", 3'd0, PCW, 1'b1, D_RST);

    instruction = I_HALT;
    step("halt.1", 3'd1, NONE, 1'b0, D_RST);
    instruction = I_ADD;
    for (int i = 0; i < 20; i++) begin
      step("halt.7", 3'd7, NONE, 1'b0, D_RST);
    end
    reset = 1'b1;
    step("halt.rst", 3'd0, NONE, 1'b1, D_RST);
    reset = 1'b0;
    step("halt.boot", 3'd0, PCW, 1'b1, D_RST);

`ifdef MULTICYCLE_CONTROL_PERF_EN
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    chk_cnt("cnt.forced", 32'hFFFF_FFFF);
    instruction = I_ADDI;
    step("wrap.1", 3'd1, NONE, 1'b1, D_ADDI);
    instruction = I_JUNK;
    step("wrap.2", 3'd2, NONE, 1'b1, D_ADDI);
    step("wrap.4", 3'd4, RGW,  1'b1, D_ADDI);
    step("wrap.0", 3'd0, PCW,  1'b0, D_ADDI);
    chk_cnt("cnt.wrap", 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  // Exclusivity and stage-4-only register writes, checked every cycle.
  always @(negedge clock) begin
    if (!reset) begin
      n_assert++;
      assert (!(mem_read && mem_write) && (!reg_write || stage == 3'd4))
      else begin
        n_fail++;
        $error("FAIL excl got rd=%b wr=%b rw=%b stage=%0d exp exclusive",
               mem_read, mem_write, reg_write, stage);
      end
    end
  end

endmodule
